// File: rtl/sincos_lut_pipe.sv
// sincos_lut_pipe: pipelined sine/cosine lookup built on a quarter-wave ROM with quadrant folding.
// Latency: 4 cycles from the accept edge to out_valid; throughput 1 sample/cycle; bubbles are carried.
// Backpressure: ce = !out_valid | out_ready gates every stage register; in_ready = ce.
//
// Ports:
//   clk, rst            : single rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake; in_angle (unsigned steps) and in_tag (sideband)
//   out_valid/out_ready : output handshake; cos_value/sin_value (two's complement, FRAC_W
//                         fractional bits), out_tag, out_err (out-of-range flag, OOR_MODE=1 only)
module sincos_lut_pipe #(
   parameter int QTR      = 90,
   parameter int ANGLE_W  = 10,
   parameter int FRAC_W   = 8,
   parameter int OUT_W    = FRAC_W + 2,
   parameter int TAG_W    = 8,
   parameter int OOR_MODE = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ANGLE_W-1:0] in_angle,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [OUT_W-1:0]   cos_value,
   output logic [OUT_W-1:0]   sin_value,
   output logic [TAG_W-1:0]   out_tag,
   output logic               out_err
);

   localparam int                 AW    = $clog2(QTR + 1);
   localparam logic [ANGLE_W:0]   FULL  = (ANGLE_W + 1)'(4 * QTR);
   localparam logic [ANGLE_W-1:0] QTR_A = ANGLE_W'(QTR);
   localparam logic [AW-1:0]      QTR_R = AW'(QTR);
   localparam logic [OUT_W-1:0]   UNITY = OUT_W'(2 ** FRAC_W);

   // Quarter-wave table entry, evaluated only at elaboration. Sine is computed with a
   // Taylor series in 2^-30 fixed point (x <= pi/2 keeps every product inside 64 bits),
   // then rounded to FRAC_W bits. Values are non-negative, so round-half-up is the same
   // as round-half-away. End points are pinned so the folding identities stay exact.
   function automatic logic [FRAC_W:0] qsin(input int k);
      longint x, x2, term, acc, r;
      x    = (longint'(k) * 64'sd1686629713) / longint'(QTR);   // k * (pi/2) / QTR
      x2   = (x * x) >>> 30;
      term = x;
      acc  = x;
      for (int n = 1; n < 12; n++) begin
         term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
         acc  = acc + term;
      end
      r = (acc * (64'sd1 <<< FRAC_W) + (64'sd1 <<< 29)) >>> 30;
      if (k == 0)   r = 0;
      if (k == QTR) r = 64'sd1 <<< FRAC_W;
      return r[FRAC_W:0];
   endfunction

   logic [FRAC_W:0] rom [0:QTR];
   for (genvar k = 0; k <= QTR; k++) begin : g_rom
      localparam logic [FRAC_W:0] V = qsin(k);
      assign rom[k] = V;
   end

   logic ce;
   assign ce       = !out_valid || out_ready;
   assign in_ready = ce;

   // Stage 0: input capture
   logic               v0;
   logic [ANGLE_W-1:0] ang0;
   logic [TAG_W-1:0]   tag0;
   // Stage 1: range-reduced angle
   logic               v1, err1;
   logic [ANGLE_W-1:0] a1;
   logic [TAG_W-1:0]   tag1;
   // Stage 2: quadrant and ROM addresses
   logic               v2, err2;
   logic [1:0]         q2;
   logic [AW-1:0]      addr_a2, addr_b2;
   logic [TAG_W-1:0]   tag2;
   // Stage 3: ROM data
   logic               v3, err3;
   logic [1:0]         q3;
   logic [FRAC_W:0]    rd_a, rd_b;
   logic [TAG_W-1:0]   tag3;

   // Range reduction
   logic [ANGLE_W:0]   ext;
   logic [ANGLE_W-1:0] a_n;
   logic               err_n;
   always_comb begin
      ext   = {1'b0, ang0};
      a_n   = ang0;
      err_n = 1'b0;
      if (ext >= FULL) begin
         if (OOR_MODE == 1) begin
            err_n = 1'b1;
            a_n   = '0;
         end else begin
            a_n = ANGLE_W'(ext % FULL);
         end
      end
   end

   // Quadrant fold: port B reads the mirrored index so cos is taken from the sine table
   logic [1:0]    q_n;
   logic [AW-1:0] r_n;
   always_comb begin
      q_n = 2'(a1 / QTR_A);
      r_n = AW'(a1 % QTR_A);
   end

   // Sign application; one table value per quadrant keeps symmetry bit-exact
   logic [OUT_W-1:0] pa, pb, cos_n, sin_n;
   always_comb begin
      pa    = OUT_W'(rd_a);
      pb    = OUT_W'(rd_b);
      cos_n = '0;
      sin_n = '0;
      if (err3) begin
         cos_n = UNITY;
      end else begin
         case (q3)
            2'd0: begin cos_n = pb;  sin_n = pa;  end
            2'd1: begin cos_n = -pa; sin_n = pb;  end
            2'd2: begin cos_n = -pb; sin_n = -pa; end
            default: begin cos_n = pa; sin_n = -pb; end
         endcase
      end
   end

   // Two-port ROM with registered read, advanced by ce like every other stage
   always_ff @(posedge clk) begin
      if (ce) begin
         rd_a <= rom[addr_a2];
         rd_b <= rom[addr_b2];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v0        <= 1'b0;
         v1        <= 1'b0;
         v2        <= 1'b0;
         v3        <= 1'b0;
         out_valid <= 1'b0;
         cos_value <= '0;
         sin_value <= '0;
         out_tag   <= '0;
         out_err   <= 1'b0;
      end else if (ce) begin
         v0        <= in_valid;
         ang0      <= in_angle;
         tag0      <= in_tag;

         v1        <= v0;
         a1        <= a_n;
         err1      <= err_n;
         tag1      <= tag0;

         v2        <= v1;
         q2        <= q_n;
         addr_a2   <= r_n;
         addr_b2   <= QTR_R - r_n;
         err2      <= err1;
         tag2      <= tag1;

         v3        <= v2;
         q3        <= q2;
         err3      <= err2;
         tag3      <= tag2;

         out_valid <= v3;
         cos_value <= cos_n;
         sin_value <= sin_n;
         out_tag   <= tag3;
         out_err   <= err3;
      end
   end

endmodule

// File: doc/sincos_lut_pipe.md
# sincos_lut_pipe

Pipelined, parametrised sine/cosine lookup for the coordinate-transform path. It accepts one angle per cycle over a valid/ready handshake and returns both signed fixed-point cosine and sine after a fixed latency. A quarter-wave ROM plus quadrant folding replaces per-angle full-circle case tables. Output-side backpressure stalls the whole pipeline. Angle step, fraction width and out-of-range policy are parameters.

## Interface
- QTR, 90: angle steps per quarter turn; full circle is 4*QTR steps (90 gives 1-degree resolution).
- ANGLE_W, 10: angle input width; must satisfy 2^ANGLE_W > 4*QTR.
- FRAC_W, 8: fractional bits; unity is 2^FRAC_W.
- OUT_W, FRAC_W+2: output width, two's complement; must be at least FRAC_W+2.
- TAG_W, 8: width of the sideband tag carried alongside each sample.
- OOR_MODE, 0: out-of-range policy. 0 reduces the angle modulo 4*QTR. 1 flags an error and forces cos = 2^FRAC_W, sin = 0.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  angle/tag present.
- in_ready  out  1  stage 0 accepts this cycle.
- in_angle  in  ANGLE_W  unsigned angle in steps.
- in_tag  in  TAG_W  opaque sideband.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- cos_value  out  OUT_W  signed round(2^FRAC_W*cos θ).
- sin_value  out  OUT_W  signed round(2^FRAC_W*sin θ).
- out_tag  out  TAG_W  tag of this sample.
- out_err  out  1  set only when OOR_MODE=1 and the input angle is ≥ 4*QTR.

## Operation
- **ROM contents:** Q[k] = round-half-away(2^FRAC_W * sin(k*90°/QTR)) for k = 0..QTR. Q[0] = 0 and Q[QTR] = 2^FRAC_W. The ROM is generated at elaboration or by script, with two read ports and a registered read.
- **S1, range:** a = in_angle when in_angle < 4*QTR. Otherwise a = in_angle mod 4*QTR (OOR_MODE=0), or set err with a = 0 (OOR_MODE=1).
- **S2, fold:** q = a / QTR and r = a mod QTR. Port A address is r; port B address is QTR−r. Register q and err.
- **S3, ROM read:** registered outputs A = Q[r], B = Q[QTR−r].
- **S4, sign and output:**
  - q0: cos = +B, sin = +A.
  - q1: cos = −A, sin = +B.
  - q2: cos = −B, sin = −A.
  - q3: cos = +A, sin = −B.
  - If err is set: cos = +2^FRAC_W and sin = 0.
  - Results are sign-extended to OUT_W.
- The tag and a valid bit travel with every stage.
- **Symmetry:** exact symmetry is guaranteed, e.g. cos(θ) = −cos(180°−θ) bit-exactly. Example: 120° gives −128, not −127.

## Timing
- **Reset:** out_valid = 0, cos_value = 0, sin_value = 0, out_tag = 0, out_err = 0, all stage valids = 0.
- in_ready may be 1 during reset; inputs presented during reset are dropped.
- **Clock enable:** ce = !out_valid | out_ready. Every stage register, ROM read enable included, advances only when ce = 1. in_ready = ce.
- **Latency:** 4 cycles from the accept edge (in_valid & in_ready) to out_valid, with no stall.
- **Throughput:** 1 sample per cycle. Bubbles are carried, not compressed.
- **Stall:** while out_valid & !out_ready, all outputs and internal state hold. No sample is lost or duplicated.
- **Simultaneous events:** out_ready rising in the same cycle as a new accept advances both; this is legal.
- **Reset mid-stream:** reset in any cycle empties the pipeline on the next edge. No partial result appears afterwards.
- **Ordering:** outputs appear strictly in input order; out_tag matches the tag accepted 4 ce-cycles earlier.

## Test plan
- **Defaults, single accepts at 0, 60, 90, 180, 270, with out_ready=1:**
  - 0 → (cos 256, sin 0)
  - 60 → (128, 222)
  - 90 → (0, 256)
  - 180 → (−256, 0)
  - 270 → (0, −256)
  - Each result appears exactly 4 cycles after accept.
- **Sweep 0..359 back-to-back:** 360 consecutive outputs with out_valid continuous. Tags match. Every value matches the quarter-wave model. 120 gives (−128, 222); 225 gives (−181, −181).
- **Out-of-range, OOR_MODE=0:** angle 370 → (252, 44) with out_err = 0. **OOR_MODE=1:** angle 1000 → (256, 0) with out_err = 1.
- **Backpressure:** stream 0..19 while toggling out_ready pseudo-randomly. Output sequence, values and tags are identical to the no-stall run. Outputs hold steady during stalls. in_ready == ce.
- **Reset mid-stream:** assert rst for 1 cycle with 3 samples in flight. The next cycle shows out_valid = 0 and outputs = 0. The first post-reset accept emerges 4 cycles later, correct.
- **Parameter variant QTR=256, FRAC_W=14, OUT_W=16:** angle 256 → (0, 16384); angle 128 → (11585, 11585); angle 768 → (0, −16384).
